// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : multi-channel request arbiter that serialises 1/2/4-byte
//               reads and writes onto an 8-bit memory/IO bus.
// Revision    : 1.0
// ============================================================================
module mem_arbiter #(
  parameter int NUM_CH    = 2,
  parameter int PRIO_MODE = 0
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic [NUM_CH-1:0]     req_valid,
  input  logic [NUM_CH-1:0]     req_we,
  input  logic [2*NUM_CH-1:0]   req_len,
  input  logic [32*NUM_CH-1:0]  req_addr,
  input  logic [32*NUM_CH-1:0]  req_wdata,
  output logic [NUM_CH-1:0]     done,
  output logic [31:0]           rdata,
  output logic                  busy,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [31:0]           mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full
);
  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] win_q, win_d, ptr_q, ptr_d;
  logic          we_q, we_d;
  logic [2:0]    n_q, n_d, cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;

  logic          gnt_found, hi_found;
  logic [IW-1:0] gnt_idx, lo_idx, hi_idx;
  logic          sel_we;
  logic [1:0]    sel_len;
  logic [31:0]   sel_addr, sel_wdata;
  logic [31:0]   cur_addr;
  logic [7:0]    wbyte;
  logic          io_stall;

  // Round-robin picks the lowest requester at or above ptr, else wraps to the lowest overall.
  always_comb begin
    lo_idx   = '0;
    hi_idx   = '0;
    hi_found = 1'b0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (req_valid[k]) begin
        lo_idx = IW'(k);
        if (IW'(k) >= ptr_q) begin
          hi_idx   = IW'(k);
          hi_found = 1'b1;
        end
      end
    end
    gnt_found = |req_valid;
    gnt_idx   = (PRIO_MODE == 1 && hi_found) ? hi_idx : lo_idx;
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_len   = 2'b00;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (gnt_idx == IW'(k)) begin
        sel_we    = req_we[k];
        sel_len   = req_len[2*k +: 2];
        sel_addr  = req_addr[32*k +: 32];
        sel_wdata = req_wdata[32*k +: 32];
      end
    end
  end

  assign cur_addr = addr_q + {29'd0, cnt_q};
  assign io_stall = (state_q == S_XFER) && we_q && (cur_addr[17:16] == 2'b11) && io_buffer_full;

  always_comb begin
    case (cnt_q[1:0])
      2'd0:    wbyte = wdata_q[7:0];
      2'd1:    wbyte = wdata_q[15:8];
      2'd2:    wbyte = wdata_q[23:16];
      default: wbyte = wdata_q[31:24];
    endcase
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    ptr_d   = ptr_q;
    we_d    = we_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          win_d   = gnt_idx;
          we_d    = sel_we;
          n_d     = (sel_len == 2'b00) ? 3'd1 : (sel_len == 2'b01) ? 3'd2 : 3'd4;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          cnt_d   = 3'd0;
          if (!sel_we) rdata_d = '0;
          if (PRIO_MODE == 1) ptr_d = (gnt_idx == IW'(NUM_CH - 1)) ? '0 : gnt_idx + IW'(1);
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        if (we_q) begin
          if (!io_stall) begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == n_q - 3'd1) state_d = S_DONE;
          end
        end else begin
          // mem_din answers the address driven in the previous cycle.
          case (cnt_q)
            3'd1:    rdata_d[7:0]   = mem_din;
            3'd2:    rdata_d[15:8]  = mem_din;
            3'd3:    rdata_d[23:16] = mem_din;
            3'd4:    rdata_d[31:24] = mem_din;
            default: ;
          endcase
          if (cnt_q == n_q) state_d = S_DONE;
          else              cnt_d   = cnt_q + 3'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_a    = '0;
    mem_dout = '0;
    mem_wr   = 1'b0;
    if (state_q == S_XFER) begin
      if (we_q) begin
        if (!io_stall) begin
          mem_a    = cur_addr;
          mem_dout = wbyte;
          mem_wr   = rdy_in;
        end
      end else if (!rdy_in && cnt_q != 3'd0) begin
        // Re-present the previous address so mem_din is still valid on resume.
        mem_a = cur_addr - 32'd1;
      end else if (cnt_q != n_q) begin
        mem_a = cur_addr;
      end
    end
  end

  always_comb begin
    done = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      done[k] = (state_q == S_DONE) && (win_q == IW'(k));
    end
  end

  assign rdata = rdata_q;
  assign busy  = (state_q != S_IDLE);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      win_q   <= '0;
      ptr_q   <= '0;
      we_q    <= 1'b0;
      n_q     <= 3'd1;
      cnt_q   <= 3'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else if (rdy_in) begin
      state_q <= state_d;
      win_q   <= win_d;
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter : self-checking bench for mem_arbiter (fixed and round-robin).
// Revision       : 1.0
// ============================================================================
module tb_mem_arbiter;
  localparam int NC   = 2;
  localparam int MAXC = 48;

  logic              clk = 1'b0, rst = 1'b1, rdy = 1'b1, iof = 1'b0;
  logic [NC-1:0]     rv_f = '0, rv_r = '0, we = '0;
  logic [2*NC-1:0]   len = '0;
  logic [32*NC-1:0]  addr = '0, wdata = '0;
  logic [NC-1:0]     done_f, done_r;
  logic [31:0]       rdata_f, rdata_r, a_f, a_r;
  logic              busy_f, busy_r, wr_f, wr_r;
  logic [7:0]        din_f = '0, din_r = '0, do_f, do_r;
  int                vec = 0, errs = 0;

  // expected trace from the reference model, and the observed trace
  logic [31:0] ex_a[MAXC];  bit ex_ca[MAXC];
  logic [7:0]  ex_do[MAXC]; bit ex_cd[MAXC];
  logic        ex_wr[MAXC], ex_bz[MAXC];
  logic [NC-1:0] ex_dn[MAXC];
  bit          ex_rc[MAXC];
  logic [31:0] ex_rdata;
  int          ex_ncyc;
  logic [31:0] ac_a[MAXC], ac_rd[MAXC];
  logic [7:0]  ac_do[MAXC];
  logic        ac_wr[MAXC], ac_bz[MAXC];
  logic [NC-1:0] ac_dn[MAXC];
  bit          rp[MAXC], ip[MAXC];

  always #5 clk = ~clk;

  mem_arbiter #(.NUM_CH(NC), .PRIO_MODE(0)) u_fix (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .req_valid(rv_f), .req_we(we),
    .req_len(len), .req_addr(addr), .req_wdata(wdata), .done(done_f),
    .rdata(rdata_f), .busy(busy_f), .mem_din(din_f), .mem_dout(do_f),
    .mem_a(a_f), .mem_wr(wr_f), .io_buffer_full(iof));

  mem_arbiter #(.NUM_CH(NC), .PRIO_MODE(1)) u_rr (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .req_valid(rv_r), .req_we(we),
    .req_len(len), .req_addr(addr), .req_wdata(wdata), .done(done_r),
    .rdata(rdata_r), .busy(busy_r), .mem_din(din_r), .mem_dout(do_r),
    .mem_a(a_r), .mem_wr(wr_r), .io_buffer_full(iof));

  function automatic logic [7:0] memf(input logic [31:0] a);
    case (a)
      32'h100: return 8'h11;
      32'h101: return 8'h22;
      32'h102: return 8'h33;
      32'h103: return 8'h44;
      default: return a[7:0] ^ {a[11:8], a[15:12]} ^ a[23:16] ^ 8'h5A;
    endcase
  endfunction

  always @(posedge clk) begin
    din_f <= memf(a_f);
    din_r <= memf(a_r);
  end

  // Transaction as a list of units: grant, n byte/address steps, (read capture), done.
  // A unit completes in a cycle with rdy high and no IO stall.
  task automatic model_txn(input int ch, input bit w, input logic [1:0] lc,
                           input logic [31:0] ad, input logic [31:0] wd);
    int n, nu, u;
    logic [31:0] ca;
    bit st;
    n  = (lc == 2'b00) ? 1 : (lc == 2'b01) ? 2 : 4;
    nu = w ? n + 2 : n + 3;
    ex_rdata = '0;
    for (int k = 0; k < n; k++) ex_rdata[8*k +: 8] = memf(ad + 32'(k));
    u = 0;
    ex_ncyc = MAXC;
    for (int c = 0; c < MAXC; c++) begin
      ex_ca[c] = 0; ex_cd[c] = 0; ex_a[c] = '0; ex_do[c] = '0;
      ex_wr[c] = 1'b0; ex_dn[c] = '0; ex_rc[c] = 0;
      ex_bz[c] = (u >= 1 && u < nu);
      st = 0;
      if (u == nu - 1) begin
        ex_dn[c][ch] = 1'b1;
        ex_rc[c] = !w;
      end
      if (w && u >= 1 && u <= n) begin
        ca = ad + 32'(u - 1);
        st = ip[c] && (ca[17:16] == 2'b11);
        ex_wr[c] = rp[c] && !st;
        ex_ca[c] = rp[c];
        ex_a[c]  = st ? 32'd0 : ca;
        ex_cd[c] = rp[c] && !st;
        ex_do[c] = wd[8*(u-1) +: 8];
      end
      if (!w && u >= 1 && u <= n + 1) begin
        ex_ca[c] = rp[c] || (u >= 2);
        if (rp[c]) ex_a[c] = (u <= n) ? ad + 32'(u - 1) : 32'd0;
        else       ex_a[c] = ad + 32'(u - 2);
      end
      if (u == nu) begin
        ex_ca[c] = 1;
        ex_ncyc  = c + 1;
        break;
      end
      if (rp[c] && !st) u++;
    end
  endtask

  // Requester on the fixed-priority instance; logs outputs every cycle.
  task automatic drive_txn(input int ch, input bit w, input logic [1:0] lc,
                           input logic [31:0] ad, input logic [31:0] wd);
    bit drop;
    drop = 0;
    we = '0;    we[ch] = w;
    len = '0;   len[2*ch +: 2] = lc;
    addr = '0;  addr[32*ch +: 32] = ad;
    wdata = '0; wdata[32*ch +: 32] = wd;
    for (int c = 0; c < ex_ncyc; c++) begin
      rdy = rp[c];
      iof = ip[c];
      rv_f = '0;
      if (!drop) rv_f[ch] = 1'b1;
      #2;
      ac_a[c] = a_f; ac_do[c] = do_f; ac_wr[c] = wr_f;
      ac_dn[c] = done_f; ac_bz[c] = busy_f; ac_rd[c] = rdata_f;
      if (done_f != '0 && rdy) drop = 1;
      @(posedge clk); #1;
    end
    rv_f = '0; rdy = 1'b1; iof = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vec++;
    if ({a_f, do_f, wr_f, done_f, rdata_f, busy_f} !== '0) begin
      errs++;
      $display("FAIL reset_fix a=%h dout=%h wr=%b done=%b rdata=%h busy=%b, want all 0",
               a_f, do_f, wr_f, done_f, rdata_f, busy_f);
    end
    vec++;
    if ({a_r, do_r, wr_r, done_r, rdata_r, busy_r} !== '0) begin
      errs++;
      $display("FAIL reset_rr a=%h dout=%h wr=%b done=%b rdata=%h busy=%b, want all 0",
               a_r, do_r, wr_r, done_r, rdata_r, busy_r);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    int t_ch[5]; bit t_we[5]; logic [1:0] t_lc[5];
    logic [31:0] t_ad[5], t_wd[5]; int t_dc[5];
    int first;
    t_ch = '{0, 1, 0, 1, 0};
    t_we = '{0, 1, 1, 0, 1};
    t_lc = '{2'b10, 2'b01, 2'b00, 2'b10, 2'b11};
    t_ad = '{32'h100, 32'h2001, 32'h30000, 32'h5000, 32'hFFFFFFFE};
    t_wd = '{32'h0, 32'hA5B6C7D8, 32'h41, 32'h0, 32'h11223344};
    t_dc = '{6, 3, 5, 8, 5};
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < MAXC; c++) begin rp[c] = 1; ip[c] = 0; end
      if (r == 2) begin ip[1] = 1; ip[2] = 1; ip[3] = 1; end
      if (r == 3) begin rp[3] = 0; rp[4] = 0; end
      model_txn(t_ch[r], t_we[r], t_lc[r], t_ad[r], t_wd[r]);
      drive_txn(t_ch[r], t_we[r], t_lc[r], t_ad[r], t_wd[r]);
      for (int c = 0; c < ex_ncyc; c++) begin
        vec++;
        if ({ac_wr[c], ac_dn[c], ac_bz[c]} !== {ex_wr[c], ex_dn[c], ex_bz[c]}) begin
          errs++;
          $display("FAIL dir%0d cyc%0d wr/done/busy got %b/%b/%b want %b/%b/%b", r, c,
                   ac_wr[c], ac_dn[c], ac_bz[c], ex_wr[c], ex_dn[c], ex_bz[c]);
        end
        if (ex_ca[c]) begin
          vec++;
          if (ac_a[c] !== ex_a[c]) begin
            errs++; $display("FAIL dir%0d cyc%0d mem_a got %h want %h", r, c, ac_a[c], ex_a[c]);
          end
        end
        if (ex_cd[c]) begin
          vec++;
          if (ac_do[c] !== ex_do[c]) begin
            errs++; $display("FAIL dir%0d cyc%0d mem_dout got %h want %h", r, c, ac_do[c], ex_do[c]);
          end
        end
        if (ex_rc[c]) begin
          vec++;
          if (ac_rd[c] !== ex_rdata) begin
            errs++; $display("FAIL dir%0d cyc%0d rdata got %h want %h", r, c, ac_rd[c], ex_rdata);
          end
        end
      end
      first = -1;
      for (int c = 0; c < ex_ncyc; c++) if (first < 0 && ac_dn[c] != '0) first = c;
      vec++;
      if (first != t_dc[r]) begin
        errs++; $display("FAIL dir%0d done_cycle got %0d want %0d", r, first, t_dc[r]);
      end
      if (r == 0) begin
        vec++;
        if (ac_rd[t_dc[r]] !== 32'h44332211) begin
          errs++; $display("FAIL dir0 rdata got %h want 44332211", ac_rd[t_dc[r]]);
        end
      end
    end
  endtask

  task automatic test_prio_fixed();
    int ord[2], cyc[2]; logic [31:0] rd[2]; int k;
    bit [NC-1:0] live;
    we = '0; len = '0; wdata = '0;
    addr = {32'h101, 32'h100};
    live = '1; k = 0;
    ord[0] = -1; ord[1] = -1; cyc[0] = -1; cyc[1] = -1; rd[0] = '0; rd[1] = '0;
    for (int c = 0; c < 16; c++) begin
      rv_f = live;
      #2;
      if (done_f != '0 && k < 2) begin
        ord[k] = (done_f == 2'b01) ? 0 : (done_f == 2'b10) ? 1 : 9;
        cyc[k] = c; rd[k] = rdata_f;
        live = live & ~done_f;
        k++;
      end
      @(posedge clk); #1;
    end
    rv_f = '0;
    for (int j = 0; j < 2; j++) begin
      vec++;
      if (ord[j] != j || cyc[j] != 3 + 4*j) begin
        errs++;
        $display("FAIL prio_fixed grant%0d got ch%0d@%0d want ch%0d@%0d", j, ord[j], cyc[j], j, 3 + 4*j);
      end
      vec++;
      if (rd[j] !== {24'h0, memf(32'h100 + 32'(j))}) begin
        errs++; $display("FAIL prio_fixed rdata%0d got %h want %h", j, rd[j], memf(32'h100 + 32'(j)));
      end
    end
  endtask

  task automatic test_rr();
    int k;
    int got_ch[4], got_c[4];
    we = '0; len = '0; wdata = '0;
    addr = {32'h103, 32'h102};
    k = 0;
    for (int j = 0; j < 4; j++) begin got_ch[j] = -1; got_c[j] = -1; end
    for (int c = 0; c < 17; c++) begin
      rv_r = (c <= 15) ? 2'b11 : 2'b00;
      #2;
      if (done_r != '0 && k < 4) begin
        got_ch[k] = (done_r == 2'b01) ? 0 : (done_r == 2'b10) ? 1 : 9;
        got_c[k] = c;
        k++;
      end
      @(posedge clk); #1;
    end
    rv_r = '0;
    for (int j = 0; j < 4; j++) begin
      vec++;
      if (got_ch[j] != j % 2 || got_c[j] != 3 + 4*j) begin
        errs++;
        $display("FAIL rr grant%0d got ch%0d@%0d want ch%0d@%0d", j, got_ch[j], got_c[j], j % 2, 3 + 4*j);
      end
    end
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int dc; logic [31:0] rd;
    we = 2'b01; len = 4'b0011; addr = {32'h102, 32'h400}; wdata = {32'h0, 32'hCAFEF00D};
    rv_f = 2'b01;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; rv_f = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #2;
      vec++;
      if (wr_f !== 1'b0 || done_f !== '0 || busy_f !== 1'b0) begin
        errs++;
        $display("FAIL reset_mid cyc%0d wr/done/busy got %b/%b/%b want 0/00/0", c, wr_f, done_f, busy_f);
      end
      @(posedge clk); #1;
    end
    we = '0; len = '0;
    dc = -1; rd = '0;
    for (int c = 0; c < 10; c++) begin
      rv_f = (dc < 0) ? 2'b10 : 2'b00;
      #2;
      if (dc < 0 && done_f == 2'b10) begin dc = c; rd = rdata_f; end
      @(posedge clk); #1;
    end
    rv_f = '0;
    vec++;
    if (dc != 3 || rd !== 32'h33) begin
      errs++; $display("FAIL reset_mid_new done@%0d rdata %h want done@3 rdata 00000033", dc, rd);
    end
  endtask

  task automatic test_random();
    int ch; bit w; logic [1:0] lc; logic [31:0] ad, wd; int mode;
    for (int t = 0; t < 40; t++) begin
      ch = $urandom_range(0, 1);
      w  = $urandom_range(0, 1) == 1;
      lc = 2'($urandom_range(0, 3));
      wd = $urandom;
      ad = $urandom;
      mode = $urandom_range(0, 3);
      if (mode == 0) ad[17:16] = 2'b11;
      if (mode == 1) ad = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
      for (int c = 0; c < MAXC; c++) begin
        rp[c] = (c < 20) ? ($urandom_range(0, 9) != 0) : 1'b1;
        ip[c] = (c < 20) ? ($urandom_range(0, 2) == 0) : 1'b0;
      end
      model_txn(ch, w, lc, ad, wd);
      drive_txn(ch, w, lc, ad, wd);
      for (int c = 0; c < ex_ncyc; c++) begin
        vec++;
        if ({ac_wr[c], ac_dn[c], ac_bz[c]} !== {ex_wr[c], ex_dn[c], ex_bz[c]}) begin
          errs++;
          $display("FAIL rnd%0d cyc%0d wr/done/busy got %b/%b/%b want %b/%b/%b", t, c,
                   ac_wr[c], ac_dn[c], ac_bz[c], ex_wr[c], ex_dn[c], ex_bz[c]);
        end
        if (ex_ca[c]) begin
          vec++;
          if (ac_a[c] !== ex_a[c]) begin
            errs++; $display("FAIL rnd%0d cyc%0d mem_a got %h want %h", t, c, ac_a[c], ex_a[c]);
          end
        end
        if (ex_cd[c]) begin
          vec++;
          if (ac_do[c] !== ex_do[c]) begin
            errs++; $display("FAIL rnd%0d cyc%0d mem_dout got %h want %h", t, c, ac_do[c], ex_do[c]);
          end
        end
        if (ex_rc[c]) begin
          vec++;
          if (ac_rd[c] !== ex_rdata) begin
            errs++; $display("FAIL rnd%0d cyc%0d rdata got %h want %h", t, c, ac_rd[c], ex_rdata);
          end
        end
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_directed();
    test_prio_fixed();
    test_rr();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Parametrised multi-channel memory controller between the pipeline's memory requesters (instruction fetch, load/store, future cache refill) and the 8-bit external memory/IO bus. It accepts up to NUM_CH independent 1/2/4-byte read or write requests. It arbitrates them by fixed priority or round-robin, then serialises each into byte cycles on mem_a/mem_dout/mem_din/mem_wr. It also handles UART back-pressure and the global rdy_in pause, and returns a one-cycle done pulse with assembled little-endian read data.

## Interface
- NUM_CH, 2: number of requester channels (1..8); channel 0 = lowest index.
- PRIO_MODE, 0: 0 = fixed priority (lowest index wins), 1 = round-robin.
- clk_in  input  1  clock; one clock domain.
- rst_in  input  1  reset, synchronous, active-high.
- rdy_in  input  1  global ready; low = freeze.
- req_valid  input  NUM_CH  request present, held until done.
- req_we  input  NUM_CH  1 = write, 0 = read.
- req_len  input  2*NUM_CH  per channel, 00 = 1 byte, 01 = 2, 10 = 4, 11 = 4.
- req_addr  input  32*NUM_CH  per-channel byte address.
- req_wdata  input  32*NUM_CH  per-channel write data; byte 0 = bits 7:0.
- done  output  NUM_CH  one-cycle pulse to the served channel.
- rdata  output  32  read data, zero-extended, valid while done is high.
- busy  output  1  high whenever FSM is not IDLE.
- mem_din  input  8  memory read byte, valid one cycle after its address.
- mem_dout  output  8  memory write byte.
- mem_a  output  32  memory address.
- mem_wr  output  1  1 = write.
- io_buffer_full  input  1  UART TX buffer full.

## Operation
- FSM states: IDLE, XFER, DONE.
- IDLE:
  - If any req_valid is high, select the winner, latch its we/len/addr/wdata, clear cnt and go to XFER.
  - Otherwise drive mem_a=0, mem_wr=0.
- Arbitration:
  - PRIO_MODE 0: the lowest set index wins.
  - PRIO_MODE 1: search starts at pointer ptr; after a grant to channel i, ptr = (i+1) mod NUM_CH; ptr resets to 0.
- XFER write, n bytes:
  - Each cycle with cnt<n: drive mem_a=addr+cnt (32-bit wrap), mem_dout=wdata byte cnt, mem_wr=1, then cnt+1.
  - After the byte with cnt=n-1, go to DONE.
- XFER read, n bytes:
  - cnt runs 0..n.
  - For cnt<n drive mem_a=addr+cnt, mem_wr=0.
  - For cnt≥1 capture mem_din into rdata byte cnt-1.
  - At cnt=n drive mem_a=0 and go to DONE after the capture.
- IO stall:
  - Applies to a write byte whose address has bits 17:16 = 2'b11 while io_buffer_full=1.
  - Behaviour: mem_wr=0, mem_a=0, cnt holds; retry each cycle.
  - Reads and non-IO writes ignore io_buffer_full.
- DONE:
  - done[winner]=1 for exactly one cycle and rdata is valid; next state is IDLE.
  - req_valid is not sampled in DONE. The requester drops or replaces its request on the edge ending the done cycle.
- rdy_in=0:
  - All registers hold and mem_wr is forced to 0.
  - During a read in XFER with cnt≥1, mem_a is driven to addr+cnt-1, so mem_din is correct on resume. Otherwise mem_a holds its last value.
  - done is held if the freeze occurs in DONE; the pulse completes on the first rdy_in=1 cycle.
- Bytes beyond len in rdata are 0. rdata holds between transactions.
- Reset mid-transfer: abort immediately, return to IDLE, no done pulse.

## Timing
- Reset values: mem_a=0, mem_dout=0, mem_wr=0, done=0, rdata=0, busy=0, ptr=0, state IDLE.
- Request first seen high in IDLE cycle 0:
  - Write of n bytes: byte cycles 1..n, done in cycle n+1.
  - Read of n bytes: addresses in cycles 1..n, last capture at the end of cycle n+1, done in cycle n+2.
- Each IO stall cycle and each rdy_in=0 cycle adds exactly one cycle.
- Back-to-back: the next grant is sampled in the IDLE cycle after DONE. Minimum request-to-request spacing is n+2 cycles for writes and n+3 for reads.
- The mem_* outputs are combinational from registered state plus rdy_in/io_buffer_full. done/rdata/busy are registered state.

## Test plan
- Single-channel read, len 10, addr 0x100, memory bytes 11 22 33 44 → addresses 0x100..0x103 in cycles 1..4, done in cycle 6, rdata=0x44332211.
- Write, len 01, addr 0x2001, wdata 0xA5B6C7D8 → mem_wr=1 with D8@0x2001 then C7@0x2002, done in cycle 3, no further write.
- Both channels request a 1-byte read in the same cycle:
  - PRIO_MODE 0: ch0 served first, then ch1.
  - PRIO_MODE 1 with all channels continuously requesting: grants alternate 0,1,0,1.
- 1-byte write of 0x41 to 0x30000 with io_buffer_full=1 for 3 cycles → mem_wr=0 for those 3 cycles, then one write of 0x41, done one cycle later.
- 4-byte read with rdy_in=0 for 2 cycles after cnt=2 → mem_a=addr+1 during the pause, rdata correct, done delayed by exactly 2 cycles.
- rst_in asserted in cycle 2 of a 4-byte write → no further mem_wr, no done, busy=0 next cycle, a new request is accepted normally.
